// File: rtl/fetch_queue.sv
// ============================================================================
// fetch_queue : instruction prefetch FIFO between fetch and decode
// Rev 1.0
// ============================================================================
`default_nettype none

module fetch_queue #(
  parameter int DEPTH = 4,
  parameter int PTR_W = 2
) (
  input  logic             clock_i,
  input  logic             reset_i,
  input  logic             flush_i,
  input  logic             in_valid_i,
  input  logic [31:0]      in_pc_i,
  input  logic [31:0]      in_instr_i,
  output logic             in_ready_o,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [31:0]      out_pc_o,
  output logic [31:0]      out_pc_plus4_o,
  output logic [31:0]      out_instr_o,
  output logic [PTR_W:0]   count_o
);

  localparam logic [PTR_W:0]   C_FULL_CNT = (PTR_W + 1)'(DEPTH);
  localparam logic [PTR_W-1:0] C_PTR_ONE  = PTR_W'(1);
  localparam logic [PTR_W:0]   C_CNT_ONE  = (PTR_W + 1)'(1);

  logic [31:0]      pc_mem_q    [DEPTH];
  logic [31:0]      instr_mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q,  count_d;
  logic             w_push, w_pop;

  // Readiness derives only from registered count: no push-through when full.
  assign in_ready_o  = (count_q != C_FULL_CNT);
  assign out_valid_o = (count_q != '0);
  assign w_push      = in_valid_i && in_ready_o;
  assign w_pop       = out_valid_o && out_ready_i;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (w_push) wr_ptr_d = wr_ptr_q + C_PTR_ONE;
      if (w_pop)  rd_ptr_d = rd_ptr_q + C_PTR_ONE;
      if (w_push && !w_pop)      count_d = count_q + C_CNT_ONE;
      else if (w_pop && !w_push) count_d = count_q - C_CNT_ONE;
    end
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset; stale contents are masked by count.
  always_ff @(posedge clock_i) begin
    if (w_push && !flush_i && !reset_i) begin
      pc_mem_q[wr_ptr_q]    <= in_pc_i;
      instr_mem_q[wr_ptr_q] <= in_instr_i;
    end
  end

  assign out_pc_o       = out_valid_o ? pc_mem_q[rd_ptr_q]    : 32'h0000_0000;
  assign out_instr_o    = out_valid_o ? instr_mem_q[rd_ptr_q] : 32'h0000_0000;
  assign out_pc_plus4_o = out_pc_o + 32'd4;
  assign count_o        = count_q;

endmodule

`default_nettype wire

// File: tb/tb_fetch_queue.sv
// ============================================================================
// tb_fetch_queue : directed + randomized bench against a queue-based model
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_fetch_queue;

  localparam int DEPTH = 4;
  localparam int PTR_W = 2;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, in_ready, out_valid, out_ready;
  logic [31:0] in_pc, in_instr, out_pc, out_pc_plus4, out_instr;
  logic [PTR_W:0] count;

  int n_checks = 0;
  int n_errors = 0;

  logic [63:0] model_q[$];   // {pc, instr}, head at index 0

  fetch_queue #(.DEPTH(DEPTH), .PTR_W(PTR_W)) u_dut (
    .clock_i        (clk),
    .reset_i        (rst),
    .flush_i        (flush),
    .in_valid_i     (in_valid),
    .in_pc_i        (in_pc),
    .in_instr_i     (in_instr),
    .in_ready_o     (in_ready),
    .out_valid_o    (out_valid),
    .out_ready_i    (out_ready),
    .out_pc_o       (out_pc),
    .out_pc_plus4_o (out_pc_plus4),
    .out_instr_o    (out_instr),
    .count_o        (count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_all();
    logic [31:0] e_pc, e_instr;
    e_pc    = (model_q.size() != 0) ? model_q[0][63:32] : 32'h0;
    e_instr = (model_q.size() != 0) ? model_q[0][31:0]  : 32'h0;
    check("count",     32'(count),     32'(model_q.size()));
    check("in_ready",  32'(in_ready),  32'(model_q.size() < DEPTH));
    check("out_valid", 32'(out_valid), 32'(model_q.size() > 0));
    check("out_pc",    out_pc,         e_pc);
    check("out_pc+4",  out_pc_plus4,   e_pc + 32'd4);
    check("out_instr", out_instr,      e_instr);
  endtask

  // Drive one cycle of inputs (called just after a falling edge), then check.
  task automatic step(input logic r, input logic f, input logic iv,
                      input logic [31:0] pc, input logic [31:0] ins, input logic ordy);
    bit do_push, do_pop;
    rst = r; flush = f; in_valid = iv; in_pc = pc; in_instr = ins; out_ready = ordy;
    do_push = iv && (model_q.size() < DEPTH);
    do_pop  = ordy && (model_q.size() > 0);
    @(posedge clk);
    if (r || f) begin
      model_q.delete();
    end else begin
      if (do_pop)  void'(model_q.pop_front());
      if (do_push) model_q.push_back({pc, ins});
    end
    @(negedge clk);
    check_all();
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_pc = '0; in_instr = '0;
    @(negedge clk);

    // Reset with a word offered
    step(1'b1, 1'b0, 1'b1, 32'h0040_0000, 32'hDEAD_BEEF, 1'b0);

    // Single word through an empty queue
    step(1'b0, 1'b0, 1'b1, 32'h0040_0020, 32'h012A_4020, 1'b0);
    check("single_pc", out_pc, 32'h0040_0020);
    check("single_pc4", out_pc_plus4, 32'h0040_0024);
    step(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1);

    // Fill past full, then drain one to admit the held fifth word
    for (int i = 0; i < 5; i++)
      step(1'b0, 1'b0, 1'b1, 32'h0040_0020 + 32'(4*i), 32'h1000_0000 + 32'(i), 1'b0);
    check("full_ready", 32'(in_ready), 32'h0);
    step(1'b0, 1'b0, 1'b1, 32'h0040_0030, 32'h1000_0004, 1'b1);
    step(1'b0, 1'b0, 1'b1, 32'h0040_0030, 32'h1000_0004, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1);

    // Streaming at count=1 across pointer wrap
    step(1'b0, 1'b0, 1'b1, 32'h0040_0020, 32'h2000_0000, 1'b0);
    for (int i = 1; i <= 10; i++)
      step(1'b0, 1'b0, 1'b1, 32'h0040_0020 + 32'(4*i), 32'h2000_0000 + 32'(i), 1'b1);
    check("stream_cnt", 32'(count), 32'd1);

    // Flush at count=3 with simultaneous push and pop
    for (int i = 0; i < 2; i++) step(1'b0, 1'b0, 1'b1, 32'h0050_0000 + 32'(4*i), 32'h3000_0000, 1'b0);
    step(1'b0, 1'b1, 1'b1, 32'h0060_0000, 32'h3333_3333, 1'b1);
    check("flush_cnt", 32'(count), 32'd0);
    step(1'b0, 1'b0, 1'b1, 32'h0040_0100, 32'h4000_0000, 1'b0);
    check("post_flush_pc", out_pc, 32'h0040_0100);

    // Flush together with reset at count=2
    step(1'b0, 1'b0, 1'b1, 32'h0040_0104, 32'h4000_0001, 1'b0);
    step(1'b1, 1'b1, 1'b1, 32'h0040_0108, 32'h4000_0002, 1'b1);

    // PC+4 wraps at the top of the address space
    step(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC, 32'h5000_0000, 1'b0);
    check("pc4_wrap", out_pc_plus4, 32'h0000_0000);
    idle();

    // Randomized traffic with occasional flush/reset
    for (int i = 0; i < 400; i++)
      step(($urandom_range(0, 99) == 0), ($urandom_range(0, 39) == 0),
           ($urandom_range(0, 99) < 65), $urandom, $urandom,
           ($urandom_range(0, 99) < 55));

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
